// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter: FSM encoding and
// requester index width.
package shift_arbiter_pkg;

   localparam int ID_W = 1;

   localparam logic [ID_W-1:0] REQ0_ID = ID_W'(0);
   localparam logic [ID_W-1:0] REQ1_ID = ID_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/barrelsft32.sv
// 32-bit combinational barrel shifter: left (zero fill), right logical or
// right arithmetic, built from five binary-weighted stages.
module barrelsft32 (
   input  logic [31:0] din,
   input  logic [4:0]  shamt,
   input  logic        lr,
   input  logic        al,
   output logic [31:0] dout
);

   logic        fill;
   logic [31:0] src, s0, s1, s2, s3, s4;

   // Left shifts reuse the right-shift stages on a bit-reversed operand.
   always_comb begin
      fill = al & ~lr & din[31];
      for (int i = 0; i < 32; i++) begin
         src[i] = lr ? din[31-i] : din[i];
      end
      s0 = shamt[0] ? {{1{fill}},  src[31:1]}  : src;
      s1 = shamt[1] ? {{2{fill}},  s0[31:2]}   : s0;
      s2 = shamt[2] ? {{4{fill}},  s1[31:4]}   : s1;
      s3 = shamt[3] ? {{8{fill}},  s2[31:8]}   : s2;
      s4 = shamt[4] ? {{16{fill}}, s3[31:16]}  : s3;
      for (int i = 0; i < 32; i++) begin
         dout[i] = lr ? s4[31-i] : s4[i];
      end
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter between two shift requesters sharing one barrel
// shifter; one operation in flight, result held until the consumer takes it.
//
//   state    | meaning
//   ST_IDLE  | waiting for a request; grant and operand capture happen here
//   ST_SHIFT | shifter runs on captured operands; result registered
//   ST_DONE  | result presented on rsp_*; wait for rsp_ready
module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_din,
   input  logic [4:0]       req0_shamt,
   input  logic             req0_LR,
   input  logic             req0_AL,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_din,
   input  logic [4:0]       req1_shamt,
   input  logic             req1_LR,
   input  logic             req1_AL,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ID_W-1:0]  rsp_id,
   output logic [31:0]      rsp_data,
   output logic [CNT_W-1:0] op_count
);

   state_t          state, state_nxt;
   logic [ID_W-1:0] last_grant, winner, op_id;
   logic [31:0]     op_din, shift_out;
   logic [4:0]      op_shamt;
   logic            op_lr, op_al, grant_en;

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      grant_en   = 1'b0;
      if (req0_valid && req1_valid) winner = ~last_grant;
      else if (req1_valid)          winner = REQ1_ID;
      else                          winner = REQ0_ID;
      case (state)
         ST_IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               grant_en   = 1'b1;
               req0_ready = (winner == REQ0_ID);
               req1_ready = (winner == REQ1_ID);
               state_nxt  = ST_SHIFT;
            end
         end
         ST_SHIFT: state_nxt = ST_DONE;
         ST_DONE:  if (rsp_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= REQ1_ID;
         op_id      <= '0;
         op_din     <= '0;
         op_shamt   <= '0;
         op_lr      <= 1'b0;
         op_al      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_data   <= '0;
         op_count   <= '0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            last_grant <= winner;
            op_id      <= winner;
            op_din     <= (winner == REQ1_ID) ? req1_din   : req0_din;
            op_shamt   <= (winner == REQ1_ID) ? req1_shamt : req0_shamt;
            op_lr      <= (winner == REQ1_ID) ? req1_LR    : req0_LR;
            op_al      <= (winner == REQ1_ID) ? req1_AL    : req0_AL;
         end
         if (state == ST_SHIFT) begin
            rsp_data  <= shift_out;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
         end
         if (state == ST_DONE && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
         end
      end
   end

   barrelsft32 u_shift (
      .din   (op_din),
      .shamt (op_shamt),
      .lr    (op_lr),
      .al    (op_al),
      .dout  (shift_out)
   );

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus predicts grants and pushes
// expected results; a monitor pops and checks them as responses are taken.
module tb_shift_arbiter;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0]      req0_din, req1_din;
   logic [4:0]       req0_shamt, req1_shamt;
   logic             req0_LR, req1_LR, req0_AL, req1_AL;
   logic             rsp_valid, rsp_ready;
   logic [0:0]       rsp_id;
   logic [31:0]      rsp_data;
   logic [CNT_W-1:0] op_count;

   shift_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
      .req0_shamt(req0_shamt), .req0_LR(req0_LR), .req0_AL(req0_AL),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
      .req1_shamt(req1_shamt), .req1_LR(req1_LR), .req1_AL(req1_AL),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [31:0] data;
      int          gcyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_cmp = 0, n_fail = 0;
   int   issued = 0, done_cnt = 0;
   logic m_last = 1'b1;
   logic granted, prev_rst, prev_v;
   logic [CNT_W-1:0] exp_count = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                             input logic lr, input logic al);
      if (lr)      return d << s;
      else if (al) return 32'($signed(d) >>> s);
      else         return d >> s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
      end
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #2;
   endtask

   // Reference arbitration: granted only while no operation is outstanding.
   task automatic cyc_end();
      logic busy, w;
      #1;
      granted = 1'b0;
      if (prev_rst && !rst) begin
         chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("reset_op_count", 32'(op_count), 32'd0);
         chk("reset_rsp_data", rsp_data, 32'd0);
         chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      end
      prev_rst = rst;
      if (rst) begin
         chk("ready_in_reset", {30'd0, req1_ready, req0_ready}, 32'd0);
         issued = done_cnt;
         m_last = 1'b1;
         return;
      end
      busy = (issued != done_cnt);
      if (!busy && (req0_valid || req1_valid)) begin
         w = (req0_valid && req1_valid) ? ~m_last : req1_valid;
         chk("grant", {30'd0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
         q.push_back('{id: w,
                       data: w ? ref_shift(req1_din, req1_shamt, req1_LR, req1_AL)
                               : ref_shift(req0_din, req0_shamt, req0_LR, req0_AL),
                       gcyc: cyc});
         issued++;
         m_last = w;
         granted = 1'b1;
      end else if (req0_ready || req1_ready) begin
         chk("no_ready_when_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
   endtask

   task automatic drive_req(input int k, input logic [31:0] d, input logic [4:0] s,
                            input logic lr, input logic al);
      if (k == 0) begin
         req0_valid = 1'b1; req0_din = d; req0_shamt = s; req0_LR = lr; req0_AL = al;
      end else begin
         req1_valid = 1'b1; req1_din = d; req1_shamt = s; req1_LR = lr; req1_AL = al;
      end
   endtask

   task automatic issue(input int k, input logic [31:0] d, input logic [4:0] s,
                        input logic lr, input logic al);
      for (int i = 0; i < 20; i++) begin
         cyc_start();
         req0_valid = 1'b0; req1_valid = 1'b0;
         drive_req(k, d, s, lr, al);
         cyc_end();
         if (granted) return;
      end
      chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_start();
         req0_valid = 1'b0; req1_valid = 1'b0;
         cyc_end();
      end
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1; prev_rst = 1'b0; prev_v = 1'b0; granted = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_din = '0; req1_din = '0; req0_shamt = '0; req1_shamt = '0;
      req0_LR = 1'b0; req1_LR = 1'b0; req0_AL = 1'b0; req1_AL = 1'b0;
      fork
         begin : stimulus
            for (int i = 0; i < 3; i++) begin
               cyc_start(); rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; cyc_end();
            end
            // both requesters held valid from reset: grants must alternate 0,1,0,1
            cyc_start(); rst = 1'b0; cyc_end();
            for (int i = 0; i < 40 && done_cnt < 4; i++) begin
               cyc_start(); req0_valid = 1'b1; req1_valid = 1'b1; cyc_end();
            end
            idle(1);
            chk("op_count_after_4", 32'(op_count), 32'd4);
            idle(3);
            // directed vectors
            issue(0, 32'h80000000, 5'd4, 1'b0, 1'b0);
            issue(1, 32'h80000000, 5'd4, 1'b0, 1'b1);
            issue(1, 32'h00000001, 5'd31, 1'b1, 1'b0);
            for (int m = 0; m < 4; m++) issue(m % 2, 32'hA5A5A5A5, 5'd0, m[1], m[0]);
            idle(4);
            // consumer stalls in DONE while both requesters keep asking
            rsp_ready = 1'b0;
            issue(0, 32'h12345678, 5'd8, 1'b1, 1'b0);
            for (int i = 0; i < 12; i++) begin
               cyc_start(); req0_valid = 1'b1; req1_valid = 1'b1; cyc_end();
            end
            cyc_start(); rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; cyc_end();
            idle(4);
            // reset during SHIFT drops the operation
            issue(1, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1);
            cyc_start(); req1_valid = 1'b0; rst = 1'b1; cyc_end();
            cyc_start(); rst = 1'b0; cyc_end();
            idle(6);
            for (int i = 0; i < 500; i++) begin
               cyc_start();
               req0_valid = ($urandom_range(0, 99) < 60);
               req1_valid = ($urandom_range(0, 99) < 60);
               req0_din = $urandom; req1_din = $urandom;
               req0_shamt = 5'($urandom); req1_shamt = 5'($urandom);
               req0_LR = 1'($urandom); req1_LR = 1'($urandom);
               req0_AL = 1'($urandom); req1_AL = 1'($urandom);
               rsp_ready = ($urandom_range(0, 99) < 70);
               cyc_end();
            end
            rsp_ready = 1'b1;
            for (int i = 0; i < 20 && issued != done_cnt; i++) idle(1);
            chk("drained", 32'(issued - done_cnt), 32'd0);
            idle(2);
         end
         begin : monitor
            forever begin
               @(posedge clk);
               #4;
               if (rst) begin
                  q.delete();
                  exp_count = '0;
                  prev_v = 1'b0;
               end else begin
                  if (rsp_valid) begin
                     if (q.size() == 0) begin
                        chk("spurious_rsp", 32'(rsp_valid), 32'd0);
                     end else begin
                        if (!prev_v) chk("latency", 32'(cyc - q[0].gcyc), 32'd2);
                        chk("rsp_data", rsp_data, q[0].data);
                        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                        chk("op_count", 32'(op_count), 32'(exp_count));
                        if (rsp_ready) begin
                           void'(q.pop_front());
                           exp_count = exp_count + 1'b1;
                           done_cnt++;
                        end
                     end
                  end
                  prev_v = rsp_valid && !rsp_ready;
               end
            end
         end
         begin : watchdog
            #200000;
            chk("watchdog_timeout", 32'd0, 32'd1);
         end
      join_any
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
